// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: state encoding, default
// sizing constants and a small index-width helper.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_BITSIZE   = 9;
    localparam int DEF_MAX_BURST = 4;

    // Width of an index into NREQ requesters, at least one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner selection: scans from last+1 (mod NREQ)
// and returns a one-hot vector of the first requester found.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int LW   = idx_width(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last,
    output logic [NREQ-1:0] winner
);

    logic          found_s;
    logic [LW-1:0] idx_s;

    // Priority scan with a running "already found" mask instead of an early exit.
    always_comb begin
        winner  = {NREQ{1'b0}};
        found_s = 1'b0;
        idx_s   = {LW{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            idx_s         = LW'((int'(last) + k) % NREQ);
            winner[idx_s] = req[idx_s] & ~found_s;
            found_s       = found_s | req[idx_s];
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one requester at a time bursts of up to
// MAX_BURST words into a FIFO. Optional word counter: FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int bitsize   = DEF_BITSIZE,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                    clk,
    input  logic                    rstp,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*bitsize-1:0] req_data,
    output logic [NREQ-1:0]         gnt,
    input  logic                    fifo_fullp,
    output logic                    fifo_writep,
    output logic [bitsize-1:0]      fifo_data_in,
    output logic [15:0]             xfer_count
);

    localparam int LW = idx_width(NREQ);
    localparam int BW = $clog2(MAX_BURST) + 1;

    arb_state_t      state_r, state_n_s;
    logic [NREQ-1:0] gnt_r, gnt_n_s;
    logic [LW-1:0]   g_idx_r, g_idx_n_s;
    logic [LW-1:0]   last_r, last_n_s;
    logic [BW-1:0]   burst_cnt_r, burst_cnt_n_s;
    logic [NREQ-1:0] winner_s;
    logic            grant_req_s;
    logic            xfer_s;
    logic            burst_end_s;
    logic [bitsize-1:0] data_s;

    function automatic logic [LW-1:0] onehot_idx(input logic [NREQ-1:0] oh);
        logic [LW-1:0] r;
        r = {LW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            r = r | (LW'(i) & {LW{oh[i]}});
        end
        return r;
    endfunction

    rr_pick #(
        .NREQ (NREQ),
        .LW   (LW)
    ) u_rr_pick (
        .req    (req),
        .last   (last_r),
        .winner (winner_s)
    );

    // Only the granted requester's req bit can qualify a transfer.
    assign grant_req_s = |(req & gnt_r);
    assign xfer_s      = (state_r == XFER) & grant_req_s & ~fifo_fullp;
    assign burst_end_s = (burst_cnt_r == BW'(MAX_BURST - 1));

    // Write data: AND-OR mux of the granted slice, zero with no grant.
    always_comb begin
        data_s = {bitsize{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            data_s = data_s | (req_data[i*bitsize +: bitsize] & {bitsize{gnt_r[i]}});
        end
    end

    assign fifo_writep  = xfer_s;
    assign fifo_data_in = data_s;
    assign gnt          = gnt_r;

    // Next-state logic: arbitrate in IDLE, count/stall/release in XFER.
    always_comb begin
        state_n_s     = state_r;
        gnt_n_s       = gnt_r;
        g_idx_n_s     = g_idx_r;
        last_n_s      = last_r;
        burst_cnt_n_s = burst_cnt_r;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_n_s     = XFER;
                    gnt_n_s       = winner_s;
                    g_idx_n_s     = onehot_idx(winner_s);
                    burst_cnt_n_s = {BW{1'b0}};
                end else begin
                    state_n_s     = IDLE;
                end
            end
            XFER: begin
                if (!grant_req_s || (xfer_s && burst_end_s)) begin
                    state_n_s     = IDLE;
                    gnt_n_s       = {NREQ{1'b0}};
                    last_n_s      = g_idx_r;
                    burst_cnt_n_s = {BW{1'b0}};
                end else if (xfer_s) begin
                    burst_cnt_n_s = burst_cnt_r + BW'(1);
                end else begin
                    // FIFO full: hold everything until space appears.
                    burst_cnt_n_s = burst_cnt_r;
                end
            end
            default: begin
                state_n_s     = IDLE;
                gnt_n_s       = {NREQ{1'b0}};
                burst_cnt_n_s = {BW{1'b0}};
            end
        endcase
    end

    // State registers; reset leaves requester 0 with first priority.
    always_ff @(posedge clk) begin
        if (rstp) begin
            state_r     <= IDLE;
            gnt_r       <= {NREQ{1'b0}};
            g_idx_r     <= {LW{1'b0}};
            last_r      <= LW'(NREQ - 1);
            burst_cnt_r <= {BW{1'b0}};
        end else begin
            state_r     <= state_n_s;
            gnt_r       <= gnt_n_s;
            g_idx_r     <= g_idx_n_s;
            last_r      <= last_n_s;
            burst_cnt_r <= burst_cnt_n_s;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] xfer_count_r;

    // Saturating count of words written to the FIFO.
    always_ff @(posedge clk) begin
        if (rstp) begin
            xfer_count_r <= 16'h0000;
        end else if (xfer_s && (xfer_count_r != 16'hFFFF)) begin
            xfer_count_r <= xfer_count_r + 16'h0001;
        end else begin
            xfer_count_r <= xfer_count_r;
        end
    end

    assign xfer_count = xfer_count_r;
`else
    assign xfer_count = 16'h0000;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The parameter list SHALL be exactly: NREQ, 4, number of requesters; bitsize, 9, data word width; MAX_BURST, 4, maximum words per grant.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rstp  input  1  reset, synchronous, active-high.
REQ-004 req  input  NREQ  per-requester write request, held while the requester has words to send.
REQ-005 req_data  input  NREQ*bitsize  concatenated requester words; requester i occupies bits [i*bitsize +: bitsize].
REQ-006 gnt  output  NREQ  registered one-hot grant; all-zero when no grant is active.
REQ-007 fifo_fullp  input  1  full flag from the downstream FIFO.
REQ-008 fifo_writep  output  1  write strobe to the FIFO.
REQ-009 fifo_data_in  output  bitsize  write data to the FIFO.
REQ-010 xfer_count  output  16  total words written to the FIFO (see Configuration).

Function
REQ-011 The state machine SHALL have exactly two states, IDLE and XFER.
REQ-012 In IDLE with any req bit set, the block SHALL load gnt with the round-robin winner on the next edge and enter XFER with burst_cnt=0.
REQ-013 Round-robin search SHALL start at index last+1 (mod NREQ), where last is the most recently released grantee.
REQ-014 A transfer SHALL occur in a cycle when state=XFER, gnt[g]=1, req[g]=1 and fifo_fullp=0.
REQ-015 fifo_writep SHALL be combinational and equal to the transfer condition; it SHALL never assert while fifo_fullp=1.
REQ-016 fifo_data_in SHALL be combinationally muxed from req_data slice g while a grant is active, and SHALL be zero otherwise.
REQ-017 Each transfer SHALL increment burst_cnt, which is clog2(MAX_BURST)+1 bits wide.
REQ-018 XFER SHALL release the grant on the next edge (gnt<=0, last<=g, state<=IDLE) when either of these holds:
  - a transfer occurs with burst_cnt==MAX_BURST-1;
  - req[g]==0.
REQ-019 With fifo_fullp=1 and req[g]=1, the block SHALL hold gnt, state and burst_cnt unchanged (stall; no timeout).
REQ-020 If req[g] drops during a stall, the grant SHALL still release per REQ-018.
REQ-021 The block SHALL spend one IDLE arbitration cycle between consecutive grants, including a re-grant to the same requester.
REQ-022 req bits of non-granted requesters SHALL NOT affect fifo_writep or fifo_data_in.

Reset
REQ-023 While rstp=1 at a clock edge, the block SHALL set:
  - state=IDLE;
  - gnt=0;
  - burst_cnt=0;
  - last=NREQ-1, so requester 0 has first priority;
  - xfer_count=0.
REQ-024 Reset asserted mid-burst SHALL abandon the burst, and fifo_writep SHALL be 0 in the cycle following the reset edge.

Configuration
REQ-025 The macro FIFO_ARB_STATS_EN SHALL compile in the word counter.
REQ-026 With FIFO_ARB_STATS_EN defined, xfer_count SHALL increment by 1 per transfer and saturate at 16'hFFFF.
REQ-027 Without FIFO_ARB_STATS_EN, the xfer_count port SHALL remain present, be tied to 0, and no counter flops SHALL be built.

Structure
REQ-028 The shared package fifo_arb_pkg SHALL hold:
  - the state encoding (IDLE=1'b0, XFER=1'b1);
  - the default NREQ, bitsize and MAX_BURST constants.
REQ-029 The round-robin winner selection SHALL live in the combinational sub-module rr_pick (inputs req and last; output one-hot winner).
REQ-030 All other logic SHALL be in fifo_wr_arbiter.

Verification
REQ-031 The bench SHALL cover the following directed scenarios (parameters at defaults unless stated):
  - Single requester: req=4'b0001 held, fifo_fullp=0 -> gnt=0001 one cycle later; 4 writes of req_data[8:0]; release; 1 idle cycle; re-grant; xfer_count=4 after the first burst.
  - All requesters, from reset: req=4'b1111 -> grant order 0,1,2,3,0; each grant carries exactly 4 fifo_writep pulses.
  - Full stall: fifo_fullp=1 for 3 cycles mid-burst after 2 writes -> gnt held, fifo_writep=0; then exactly 2 more writes before release.
  - Early drop: requester 2 drops req after 1 write -> release next edge; last=2, so next winner search starts at 3.
  - Reset mid-burst: rstp=1 during XFER -> gnt=0, fifo_writep=0, xfer_count=0; a subsequent req=4'b1000 with last=3 grants requester 3.
  - Build without FIFO_ARB_STATS_EN -> xfer_count stays 0 through the all-requesters scenario.
